// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl - round sequencer for the factorization quiz game.
//
// Runs a game of ROUNDS questions. For each round it picks a question index
// for the question DB, waits for the DB to settle, and then opens the answer
// window. It applies the judged verdict to HP/SCORE, shows the result for
// RESULT_CYC cycles, and ends in CLEAR (win) or OVER (lose).
//
// Build option: define QUIZ_TIMER_EN to enable the per-question timeout.
// Without it ASK waits indefinitely and TIME_LEFT is tied to 0.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-low reset
//   START      in   start/restart pulse (IDLE, CLEAR, OVER only)
//   ANS_VALID  in   answer submitted pulse
//   ANS_OK     in   submitted answer is correct (qualifies ANS_VALID)
//   SKIP       in   give up on the current question
//   NUM        out  question index to the DB
//   ANS_EN     out  answer entry allowed (ASK only)
//   STATE      out  state code for the 7-segment decoders
//   HP         out  remaining HP
//   ROUND      out  current round, 1-based
//   SCORE      out  correct answers this game
//   TIME_LEFT  out  seconds remaining on the current question
//   WIN        out  high in CLEAR
//   LOSE       out  high in OVER
module quiz_round_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int TIME_LIMIT = 30,
    parameter int ROUNDS     = 5,
    parameter int HP_INIT    = 3,
    parameter int DB_LAT     = 1,
    parameter int RESULT_CYC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ANS_VALID,
    input  logic       ANS_OK,
    input  logic       SKIP,
    output logic [3:0] NUM,
    output logic       ANS_EN,
    output logic [2:0] STATE,
    output logic [1:0] HP,
    output logic [3:0] ROUND,
    output logic [3:0] SCORE,
    output logic [5:0] TIME_LEFT,
    output logic       WIN,
    output logic       LOSE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ASK    = 3'd2,
        JUDGE  = 3'd3,
        RESULT = 3'd4,
        CLEAR  = 3'd5,
        OVER   = 3'd6
    } state_t;

    // Shared dwell counter for LOAD and RESULT; sized for the longer of the two.
    localparam int CW = $clog2(RESULT_CYC + DB_LAT + 2);
    localparam logic [CW-1:0] LOAD_LAST = CW'(DB_LAT);
    localparam logic [CW-1:0] RES_LAST  = CW'(RESULT_CYC - 1);

    // Out-of-range configurations elaborate a visibly named empty block.
    if (TICK_DIV < 1 || TIME_LIMIT < 1 || TIME_LIMIT > 63 || ROUNDS < 1 || ROUNDS > 15 ||
        HP_INIT < 1 || HP_INIT > 3 || DB_LAT < 0 || DB_LAT > 7 || RESULT_CYC < 1) begin : g_bad_param
    end

    state_t          state, state_nxt;
    logic [3:0]      lfsr, prev, num;
    logic [1:0]      hp;
    logic [3:0]      round, score;
    logic            verdict, verdict_nxt;
    logic [CW-1:0]   cnt;
    logic            ans_en, win, lose;
    logic            new_game, load_go, ask_go, round_inc;
    logic            timeout;
    logic [3:0]      cand, pick;

    // Candidate index 0..14; fall back to the raw LFSR value (may be 15)
    // so the same question is never asked twice in a row.
    assign cand = lfsr - 4'd1;
    assign pick = (cand == prev) ? lfsr : cand;

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        verdict_nxt = verdict;
        new_game    = 1'b0;
        load_go     = 1'b0;
        ask_go      = 1'b0;
        round_inc   = 1'b0;
        case (state)
            IDLE, CLEAR, OVER: begin
                if (START) begin
                    state_nxt = LOAD;
                    new_game  = 1'b1;
                    load_go   = 1'b1;
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = ASK;
                    ask_go    = 1'b1;
                end
            end
            ASK: begin
                if (ANS_VALID) begin
                    verdict_nxt = ANS_OK;
                    state_nxt   = JUDGE;
                end else if (SKIP || timeout) begin
                    verdict_nxt = 1'b0;
                    state_nxt   = JUDGE;
                end
            end
            JUDGE: state_nxt = RESULT;
            RESULT: begin
                if (cnt == RES_LAST) begin
                    if (hp == 2'd0)                state_nxt = OVER;
                    else if (round == 4'(ROUNDS))  state_nxt = CLEAR;
                    else begin
                        state_nxt = LOAD;
                        load_go   = 1'b1;
                        round_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            lfsr    <= 4'b1001;
            prev    <= 4'hF;
            num     <= 4'd0;
            hp      <= 2'(HP_INIT);
            round   <= 4'd0;
            score   <= 4'd0;
            verdict <= 1'b0;
            cnt     <= '0;
            ans_en  <= 1'b0;
            win     <= 1'b0;
            lose    <= 1'b0;
        end else begin
            // x^4 + x^3 + 1, free-running in every state
            lfsr    <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            verdict <= verdict_nxt;

            if ((state == LOAD || state == RESULT) && state_nxt == state) cnt <= cnt + 1'b1;
            else                                                          cnt <= '0;

            if (new_game) begin
                hp    <= 2'(HP_INIT);
                score <= 4'd0;
                round <= 4'd1;
            end else if (round_inc) begin
                round <= round + 4'd1;
            end

            if (load_go) begin
                num  <= pick;
                prev <= pick;
            end

            if (state == JUDGE) begin
                if (verdict) begin
                    if (score != 4'hF) score <= score + 4'd1;
                end else begin
                    if (hp != 2'd0) hp <= hp - 2'd1;
                end
            end

            ans_en <= (state_nxt == ASK);
            win    <= (state_nxt == CLEAR);
            lose   <= (state_nxt == OVER);
        end
    end

`ifdef QUIZ_TIMER_EN
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] div;
    logic [5:0]    time_left;
    logic          tick;

    assign tick    = (state == ASK) && (div == DW'(TICK_DIV - 1));
    // The tick that would write 0 also ends the question on the same edge.
    assign timeout = tick && (time_left == 6'd1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            div       <= '0;
            time_left <= 6'd0;
        end else if (ask_go) begin
            div       <= '0;
            time_left <= 6'(TIME_LIMIT);
        end else if (state == ASK) begin
            if (tick) begin
                div       <= '0;
                time_left <= time_left - 6'd1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign TIME_LEFT = time_left;
`else
    assign timeout   = 1'b0;
    assign TIME_LEFT = 6'd0;
`endif

    assign NUM    = num;
    assign ANS_EN = ans_en;
    assign STATE  = state;
    assign HP     = hp;
    assign ROUND  = round;
    assign SCORE  = score;
    assign WIN    = win;
    assign LOSE   = lose;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
module tb_quiz_round_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int TIME_LIMIT = 3;
    localparam int ROUNDS     = 2;
    localparam int HP_INIT    = 2;
    localparam int DB_LAT     = 1;
    localparam int RESULT_CYC = 2;
`ifdef QUIZ_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam int TL0 = TIMER ? TIME_LIMIT : 0;

    logic       CLK, RST, START, ANS_VALID, ANS_OK, SKIP;
    logic [3:0] NUM, ROUND, SCORE;
    logic       ANS_EN, WIN, LOSE;
    logic [2:0] STATE;
    logic [1:0] HP;
    logic [5:0] TIME_LEFT;

    quiz_round_ctrl #(
        .TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT), .ROUNDS(ROUNDS),
        .HP_INIT(HP_INIT), .DB_LAT(DB_LAT), .RESULT_CYC(RESULT_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ANS_VALID(ANS_VALID), .ANS_OK(ANS_OK),
        .SKIP(SKIP), .NUM(NUM), .ANS_EN(ANS_EN), .STATE(STATE), .HP(HP), .ROUND(ROUND),
        .SCORE(SCORE), .TIME_LEFT(TIME_LEFT), .WIN(WIN), .LOSE(LOSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] num;
        logic       ae;
        logic [1:0] hp;
        logic [3:0] rnd;
        logic [3:0] sc;
        logic [5:0] tl;
        logic       w;
        logic       l;
    } snap_t;

    snap_t sbq[$];
    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: game-level bookkeeping driven by the rules of play.
    int m_st, m_num, m_hp, m_rnd, m_sc, m_tl, m_lfsr, m_prev, m_cnt, m_div;
    bit m_ver;

    function automatic int lfsr_next(int v);
        return ((v << 1) & 15) | (((v >> 3) ^ (v >> 2)) & 1);
    endfunction

    task automatic enter_load(int lf);
        int c;
        c     = lf - 1;
        m_num = (c == m_prev) ? lf : c;
        m_prev = m_num;
        m_st  = 1;
        m_cnt = 0;
    endtask

    task automatic model_step(bit rst, bit st, bit av, bit ok, bit sk);
        int lf;
        bit to;
        snap_t e;
        to = 1'b0;
        if (!rst) begin
            m_st = 0; m_num = 0; m_hp = HP_INIT; m_rnd = 0; m_sc = 0; m_tl = 0;
            m_lfsr = 9; m_prev = 15; m_cnt = 0; m_div = 0; m_ver = 1'b0;
        end else begin
            lf = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            case (m_st)
                0, 5, 6: if (st) begin
                    m_hp = HP_INIT; m_sc = 0; m_rnd = 1;
                    enter_load(lf);
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == DB_LAT + 1) begin
                        m_st = 2; m_tl = TL0; m_div = 0;
                    end
                end
                2: begin
                    if (TIMER) begin
                        m_div++;
                        if (m_div == TICK_DIV) begin
                            m_div = 0;
                            m_tl--;
                            to = (m_tl == 0);
                        end
                    end
                    if (av) begin
                        m_ver = ok; m_st = 3;
                    end else if (sk || to) begin
                        m_ver = 1'b0; m_st = 3;
                    end
                end
                3: begin
                    if (m_ver) m_sc = (m_sc < 15) ? m_sc + 1 : 15;
                    else       m_hp = (m_hp > 0) ? m_hp - 1 : 0;
                    m_st = 4; m_cnt = 0;
                end
                4: begin
                    m_cnt++;
                    if (m_cnt == RESULT_CYC) begin
                        if (m_hp == 0)           m_st = 6;
                        else if (m_rnd == ROUNDS) m_st = 5;
                        else begin
                            m_rnd++;
                            enter_load(lf);
                        end
                    end
                end
                default: m_st = 0;
            endcase
        end
        e.st = 3'(m_st); e.num = 4'(m_num); e.ae = (m_st == 2); e.hp = 2'(m_hp);
        e.rnd = 4'(m_rnd); e.sc = 4'(m_sc); e.tl = 6'(m_tl);
        e.w = (m_st == 5); e.l = (m_st == 6);
        sbq.push_back(e);
    endtask

    // One clock: drive at the falling edge, predict, return just after the rising edge.
    task automatic cyc(bit rst, bit st, bit av, bit ok, bit sk);
        @(negedge CLK);
        RST = rst; START = st; ANS_VALID = av; ANS_OK = ok; SKIP = sk;
        model_step(rst, st, av, ok, sk);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected snapshot per clock the DUT has been driven for.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = '{STATE, NUM, ANS_EN, HP, ROUND, SCORE, TIME_LEFT, WIN, LOSE};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got st=%0d num=%0d ae=%0d hp=%0d rnd=%0d sc=%0d tl=%0d w=%0d l=%0d, expected st=%0d num=%0d ae=%0d hp=%0d rnd=%0d sc=%0d tl=%0d w=%0d l=%0d",
                             $time, a.st, a.num, a.ae, a.hp, a.rnd, a.sc, a.tl, a.w, a.l,
                             e.st, e.num, e.ae, e.hp, e.rnd, e.sc, e.tl, e.w, e.l);
                end
            end
        end
    end

    initial begin
        int avr, skr;
        RST = 1'b0; START = 1'b0; ANS_VALID = 1'b0; ANS_OK = 1'b0; SKIP = 1'b0;

        // Reset state
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset_state", STATE, 0);
        chk("reset_hp", HP, HP_INIT);
        chk("reset_round", ROUND, 0);
        chk("reset_num", NUM, 0);
        chk("reset_time_left", TIME_LEFT, 0);

        // START -> LOAD x2 -> ASK, first index from LFSR 9
        cyc(1, 1, 0, 0, 0);
        chk("start_load", STATE, 1);
        chk("first_num", NUM, 8);
        chk("start_round", ROUND, 1);
        idle(1);
        chk("load_hold", STATE, 1);
        idle(1);
        chk("ask_entry", STATE, 2);
        chk("ask_ans_en", ANS_EN, 1);
        chk("ask_time_left", TIME_LEFT, TL0);

        // Two correct answers -> CLEAR
        cyc(1, 0, 1, 1, 0);
        chk("judge_state", STATE, 3);
        idle(1);
        chk("result_state", STATE, 4);
        chk("score_1", SCORE, 1);
        idle(2);
        chk("round_2_load", STATE, 1);
        chk("round_2", ROUND, 2);
        idle(2);
        cyc(1, 0, 1, 1, 0);
        idle(3);
        chk("clear_state", STATE, 5);
        chk("clear_win", WIN, 1);
        chk("clear_score", SCORE, 2);
        chk("clear_hp", HP, 2);

        // Restart from CLEAR
        cyc(1, 1, 0, 0, 0);
        chk("restart_state", STATE, 1);
        chk("restart_score", SCORE, 0);
        chk("restart_round", ROUND, 1);
        idle(2);

        // First question lost: timeout, or an explicit wrong answer without the timer
        if (TIMER) begin
            for (int i = 1; i <= 12; i++) begin
                cyc(1, 0, 0, 0, 0);
                if (i == 4)  chk("tl_2", TIME_LEFT, 2);
                if (i == 8)  chk("tl_1", TIME_LEFT, 1);
                if (i == 11) chk("tl_pre_timeout_state", STATE, 2);
                if (i == 12) begin
                    chk("timeout_state", STATE, 3);
                    chk("timeout_tl", TIME_LEFT, 0);
                end
            end
        end else begin
            idle(110);
            chk("no_timer_hold_state", STATE, 2);
            chk("no_timer_tl", TIME_LEFT, 0);
            cyc(1, 0, 1, 0, 0);
            chk("wrong_judge", STATE, 3);
        end
        idle(1);
        chk("hp_after_wrong", HP, 1);
        idle(4);
        cyc(1, 0, 0, 0, 1);
        idle(3);
        chk("over_state", STATE, 6);
        chk("over_lose", LOSE, 1);
        chk("over_round", ROUND, 2);
        chk("over_hp", HP, 0);
        cyc(1, 0, 1, 1, 0);
        chk("over_ignore_state", STATE, 6);
        chk("over_ignore_score", SCORE, 0);

        // ANS_VALID wins over SKIP (and timeout when enabled)
        cyc(1, 1, 0, 0, 0);
        idle(2);
        if (TIMER) idle(11);
        cyc(1, 0, 1, 1, 1);
        chk("prio_judge", STATE, 3);
        idle(1);
        chk("prio_score", SCORE, 1);
        chk("prio_hp", HP, 2);

        // Reset during RESULT
        cyc(0, 0, 0, 0, 0);
        chk("midrst_state", STATE, 0);
        chk("midrst_hp", HP, 2);
        chk("midrst_score", SCORE, 0);
        chk("midrst_round", ROUND, 0);

        // Randomized traffic with varying pressure
        for (int b = 0; b < 8; b++) begin
            avr = $urandom_range(2, 30);
            skr = $urandom_range(3, 40);
            for (int i = 0; i < 500; i++) begin
                cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, avr) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, skr) == 0));
            end
        end

        @(negedge CLK);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round sequencer for the factorization quiz game. It starts a game and selects each question index for the question DB. It opens and closes the answer-entry window, enforces a per-question time limit, and applies the judged result to the player's HP and score. It ends the game on HP exhaustion (lose) or after the last round (win). It sits between the board push-buttons and the question DB / answer-input datapath, and drives the state code used by the 7-segment decoders.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per one-second tick.
- TIME_LIMIT, 30: seconds allowed per question, 1..63.
- ROUNDS, 5: questions per game, 1..15.
- HP_INIT, 3: starting HP, 1..3.
- DB_LAT, 1: cycles from NUM change to valid QUESTION at the DB output, 0..7.
- RESULT_CYC, 50_000_000: cycles the result is held before advancing, ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- START  in  1  one-cycle pulse, debounced upstream.
- ANS_VALID  in  1  one-cycle pulse: player pressed DEC with a complete answer.
- ANS_OK  in  1  answer correct; qualifies ANS_VALID only.
- SKIP  in  1  one-cycle pulse: player gives up on the current question.
- NUM  out  4  question index to the DB.
- ANS_EN  out  1  answer entry allowed.
- STATE  out  3  current state code.
- HP  out  2  remaining HP.
- ROUND  out  4  current round, 1-based.
- SCORE  out  4  correct answers this game.
- TIME_LEFT  out  6  seconds remaining.
- WIN  out  1  high in CLEAR.
- LOSE  out  1  high in OVER.

## Operation
- States and codes: IDLE=0, LOAD=1, ASK=2, JUDGE=3, RESULT=4, CLEAR=5, OVER=6.
- Reset values: STATE=IDLE, NUM=0, ANS_EN=0, HP=HP_INIT, ROUND=0, SCORE=0, TIME_LEFT=0, WIN=0, LOSE=0. LFSR=4'b1001, the previous-index register=4'hF.
- A 4-bit maximal LFSR (x^4+x^3+1) advances every cycle, including in IDLE.
- START in IDLE, CLEAR or OVER: HP←HP_INIT, SCORE←0, ROUND←1, go to LOAD. START in any other state is ignored.
- LOAD, on entry: NUM←LFSR−1, giving 0..14. If that equals the previous index, NUM←LFSR instead; 15 is legal.
- LOAD stays DB_LAT+1 cycles, then goes to ASK. On entry to ASK: TIME_LEFT←TIME_LIMIT and the tick divider clears.
- ASK: ANS_EN=1.
  - ANS_VALID: latch ANS_OK as the verdict and go to JUDGE.
  - SKIP, or TIME_LEFT reaching 0: verdict=wrong, go to JUDGE.
  - Priority when simultaneous: ANS_VALID > SKIP > timeout.
- JUDGE, one cycle: a correct verdict gives SCORE+1, saturating at 15. A wrong verdict gives HP−1, saturating at 0. Go to RESULT.
- RESULT holds RESULT_CYC cycles. Then the first matching rule applies:
  - HP=0 → OVER.
  - ROUND=ROUNDS → CLEAR.
  - Otherwise ROUND+1 → LOAD.
- CLEAR and OVER hold until START.
- ANS_VALID, ANS_OK and SKIP outside ASK are ignored. ANS_EN is 0 in every state except ASK.
- RST low at any cycle restores all reset values on that edge, mid-round included.

## Timing
- All outputs are registered and change only on a CLK rising edge.
- START pulse at edge n: STATE=LOAD after edge n.
- ASK after DB_LAT+1 further edges.
- ANS_VALID at edge m: STATE=JUDGE after m; HP/SCORE updated and STATE=RESULT after m+1.
- TIME_LEFT decrements once per TICK_DIV cycles spent in ASK. The edge that writes 0 also leaves ASK, i.e. STATE=JUDGE on that edge.
- The tick divider and TIME_LEFT freeze outside ASK.

## Configuration
- QUIZ_TIMER_EN defined: per-question timeout as specified above.
- QUIZ_TIMER_EN undefined:
  - No tick divider; TIME_LEFT is tied to 0.
  - ASK waits indefinitely for ANS_VALID or SKIP.
  - TIME_LIMIT and TICK_DIV are unused.
  - All other behaviour is identical.

## Test plan
Parameters: TICK_DIV=4, TIME_LIMIT=3, ROUNDS=2, HP_INIT=2, DB_LAT=1, RESULT_CYC=2.
- Reset, then START: STATE sequence 0→1→1→2. ANS_EN=1 and TIME_LEFT=3 when entering ASK. NUM=8, from LFSR 9 at the LOAD entry.
- Two correct answers: SCORE=2, HP=2, ROUND=2, end in CLEAR with WIN=1. A following START gives SCORE=0, ROUND=1, STATE=LOAD.
- No answer, timer enabled: TIME_LEFT goes 3→2→1→0 every 4 cycles, and STATE=JUDGE on the edge that writes 0. HP 2→1.
- Wrong answer then SKIP: HP=0, OVER with LOSE=1, ROUND=2. ANS_VALID in OVER leaves all outputs unchanged.
- ANS_VALID (ANS_OK=1) in the same cycle as SKIP and timeout: the verdict is correct, SCORE+1 and HP unchanged.
- RST low during RESULT: next edge gives STATE=0, HP=2, SCORE=0, ROUND=0. Without QUIZ_TIMER_EN, ASK holds for more than 100 cycles with TIME_LEFT=0.
